// File: rtl/video_clken_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_clken_pkg
// Purpose  : Shared state encoding and limits for the video clock-enable gen.
// Revision : 1.0  initial release
// ============================================================================
package video_clken_pkg;

    localparam int MAX_CLOCKS = 8;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } clken_state_t;

endpackage
`default_nettype wire

// File: rtl/video_clken_chan.sv
`default_nettype none
// ============================================================================
// Module   : video_clken_chan
// Purpose  : One phase-accumulator channel; emits the registered carry pulse.
// Revision : 1.0  initial release
// ============================================================================
module video_clken_chan
    import video_clken_pkg::*;
#(
    parameter int                   ACC_WIDTH = 32,
    parameter logic [ACC_WIDTH-1:0] INIT_INCR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [ACC_WIDTH-1:0] i_wr_incr,
    output logic                 o_pulse
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_incr;
    logic                 r_pulse;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_incr};

    // The increment update is independent of the clear so a restart and a
    // write in the same cycle both land; the accumulator is never touched by
    // a write, keeping rate changes phase-continuous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_incr  <= INIT_INCR;
            r_pulse <= 1'b0;
        end else begin
            if (i_clear) begin
                r_acc   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_acc   <= w_sum[ACC_WIDTH-1:0];
                r_pulse <= w_sum[ACC_WIDTH];
            end
            if (i_wr_en) begin
                r_incr <= i_wr_incr;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/video_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_clken_gen
// Purpose  : Multi-channel fractional clock-enable generator with lock status.
// Revision : 1.0  initial release
// ============================================================================
module video_clken_gen
    import video_clken_pkg::*;
#(
    parameter int                              NUM_CLOCKS  = 3,
    parameter int                              ACC_WIDTH   = 32,
    parameter int                              LOCK_CYCLES = 1024,
    parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INIT_INCR   =
        {32'hA8F5C290, 32'h80000000, 32'h80000000}
) (
    input  logic                          refclk,
    input  logic                          rst,
    input  logic                          sync_restart,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [$clog2(MAX_CLOCKS)-1:0] cfg_chan,
    input  logic [ACC_WIDTH-1:0]          cfg_incr,
    output logic [NUM_CLOCKS-1:0]         outclk_en,
    output logic                          locked
);

    localparam int                  c_chan_w     = $clog2(MAX_CLOCKS);
    localparam int                  c_cnt_w      = $clog2(LOCK_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_cnt_last   = c_cnt_w'(LOCK_CYCLES - 1);
    localparam logic [c_chan_w:0]   c_num_clocks = (c_chan_w + 1)'(NUM_CLOCKS);

    clken_state_t         r_state;
    clken_state_t         w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_accept;
    logic                 w_restart;

    assign cfg_ready = (r_state != ST_RESET);
    assign locked    = (r_state == ST_LOCKED);

    // Writes to channels that do not exist are consumed but have no effect.
    assign w_accept  = cfg_valid && cfg_ready && ({1'b0, cfg_chan} < c_num_clocks);
    assign w_restart = sync_restart || w_accept;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = '0;
            end
            ST_SETTLE: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            ST_LOCKED: begin
                w_state_nxt = ST_LOCKED;
            end
            default: begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
        if ((r_state != ST_RESET) && w_restart) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = '0;
        end
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        video_clken_chan #(
            .ACC_WIDTH (ACC_WIDTH),
            .INIT_INCR (INIT_INCR[i*ACC_WIDTH +: ACC_WIDTH])
        ) u_chan (
            .clk       (refclk),
            .rst       (rst),
            .i_clear   (sync_restart),
            .i_wr_en   (w_accept && (cfg_chan == c_chan_w'(i))),
            .i_wr_incr (cfg_incr),
            .o_pulse   (outclk_en[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_video_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_clken_gen
// Purpose  : Self-checking bench: vector table, directed corners, random run.
// Revision : 1.0  initial release
// ============================================================================
module tb_video_clken_gen;

    localparam int N = 3;
    localparam int W = 32;
    localparam int L = 1024;

    logic         refclk = 1'b0;
    logic         rst;
    logic         sync_restart;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [2:0]   cfg_chan;
    logic [W-1:0] cfg_incr;
    logic [N-1:0] outclk_en;
    logic         locked;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-channel phase as plain integers plus the edge
    // index of the last restart event.
    longint unsigned m_acc [N];
    longint unsigned m_incr[N];
    logic [N-1:0]    m_en;
    bit              m_in_reset;
    longint          m_edge;
    longint          m_last;

    typedef struct {
        logic [2:0]  chan;
        logic [31:0] incr;
        int          window;
        int          exp_cnt;
    } vec_t;
    vec_t vecs[8];

    video_clken_gen #(
        .NUM_CLOCKS  (N),
        .ACC_WIDTH   (W),
        .LOCK_CYCLES (L),
        .INIT_INCR   ({32'hA8F5C290, 32'h80000000, 32'h80000000})
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_incr     (cfg_incr),
        .outclk_en    (outclk_en),
        .locked       (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
        m_incr[0]  = 64'h80000000;
        m_incr[1]  = 64'h80000000;
        m_incr[2]  = 64'hA8F5C290;
        m_en       = '0;
        m_in_reset = 1'b1;
    endtask

    task automatic model_edge();
        bit              ok;
        longint unsigned s;
        if (rst) begin
            model_reset();
            return;
        end
        ok = cfg_valid && !m_in_reset && (cfg_chan < N);
        for (int i = 0; i < N; i++) begin
            if (sync_restart) begin
                m_acc[i] = 0;
                m_en[i]  = 1'b0;
            end else begin
                s        = m_acc[i] + m_incr[i];
                m_en[i]  = (s >= (64'd1 << W));
                m_acc[i] = s % (64'd1 << W);
            end
        end
        if (ok) m_incr[cfg_chan] = {32'd0, cfg_incr};
        m_edge++;
        if (m_in_reset) begin
            m_in_reset = 1'b0;
            m_last     = m_edge;
        end else if (sync_restart || ok) begin
            m_last = m_edge;
        end
    endtask

    function automatic logic m_locked();
        return !m_in_reset && ((m_edge - m_last) >= L);
    endfunction

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        check("outclk_en", {61'd0, outclk_en}, {61'd0, m_en});
        check("locked",    {63'd0, locked},    {63'd0, m_locked()});
        check("cfg_ready", {63'd0, cfg_ready}, {63'd0, !m_in_reset});
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [31:0] inc, input logic sr);
        cfg_valid    = 1'b1;
        cfg_chan     = ch;
        cfg_incr     = inc;
        sync_restart = sr;
        step();
        cfg_valid    = 1'b0;
        sync_restart = 1'b0;
    endtask

    task automatic wait_locked(input int already, output int cycles);
        cycles = -1;
        for (int k = already + 1; k <= already + 1100; k++) begin
            step();
            if (locked === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int ch, input int window, output int cnt);
        cnt = 0;
        for (int k = 0; k < window; k++) begin
            step();
            if (outclk_en[ch] === 1'b1) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         cyc;
        int         cnt;
        bit         found;
        logic [7:0] pat;
        int         r;

        rst = 1'b1; sync_restart = 1'b0; cfg_valid = 1'b0;
        cfg_chan = '0; cfg_incr = '0;
        model_reset();
        m_edge = 0;
        m_last = 0;

        vecs[0] = '{3'd2, 32'hA8F5C290, 100, 66};
        vecs[1] = '{3'd1, 32'h40000000, 100, 25};
        vecs[2] = '{3'd0, 32'h00000000, 100, 0};
        vecs[3] = '{3'd0, 32'hFFFFFFFF, 100, 99};
        vecs[4] = '{3'd1, 32'h00000001, 100, 0};
        vecs[5] = '{3'd2, 32'h55555555, 30, 9};
        vecs[6] = '{3'd1, 32'hC0000000, 8, 6};
        vecs[7] = '{3'd0, 32'h80000000, 7, 3};

        // Reset state
        repeat (3) step();
        check("rst_outclk_en", {61'd0, outclk_en}, 64'd0);
        check("rst_locked",    {63'd0, locked},    64'd0);
        check("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);

        // Release with default increments: channels 0/1 toggle every cycle
        rst = 1'b0;
        step(); check("e0_en01", {62'd0, outclk_en[1:0]}, 64'd0);
        step(); check("e1_en01", {62'd0, outclk_en[1:0]}, 64'd3);
        step(); check("e2_en01", {62'd0, outclk_en[1:0]}, 64'd0);
        step(); check("e3_en01", {62'd0, outclk_en[1:0]}, 64'd3);
        wait_locked(3, cyc);
        check("lock_after_release", 64'(cyc), 64'(L));

        // Rate change while locked
        do_write(3'd1, 32'h40000000, 1'b0);
        check("lock_drop_on_write", {63'd0, locked}, 64'd0);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (outclk_en[1] === 1'b1) cnt++;
        end
        check("ch1_quarter_rate", 64'(cnt), 64'd4);
        wait_locked(16, cyc);
        check("relock_after_write", 64'(cyc), 64'(L));

        // Out-of-range channel is ignored
        do_write(3'd5, 32'h12345678, 1'b0);
        check("bad_chan_locked", {63'd0, locked}, 64'd1);
        count_pulses(1, 8, cnt);
        check("bad_chan_ch1_rate", 64'(cnt), 64'd2);
        check("bad_chan_locked_later", {63'd0, locked}, 64'd1);

        // Restart and write in the same cycle
        do_write(3'd0, 32'h40000000, 1'b1);
        check("sr_clear", {61'd0, outclk_en}, 64'd0);
        check("sr_unlock", {63'd0, locked}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            pat[k] = outclk_en[0];
        end
        check("sr_ch0_pattern", {56'd0, pat}, 64'h88);
        wait_locked(8, cyc);
        check("relock_after_sr", 64'(cyc), 64'(L));

        // Vector table: program, restart for alignment, count pulses
        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].chan, vecs[i].incr, 1'b0);
            sync_restart = 1'b1;
            step();
            sync_restart = 1'b0;
            count_pulses(int'(vecs[i].chan), vecs[i].window, cnt);
            check($sformatf("vec%0d_count", i), 64'(cnt), 64'(vecs[i].exp_cnt));
        end

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            sync_restart = ($urandom_range(0, 99) == 0);
            cfg_valid    = ($urandom_range(0, 15) == 0);
            cfg_chan     = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 7);
            case (r)
                0:       cfg_incr = 32'h0;
                1:       cfg_incr = 32'hFFFFFFFF;
                2:       cfg_incr = 32'h80000000;
                default: cfg_incr = $urandom;
            endcase
            step();
        end
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;

        // Asynchronous reset mid-settle with a write in flight
        do_write(3'd0, 32'h80000000, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (outclk_en !== '0) begin
                found = 1'b1;
                break;
            end
        end
        check("pre_rst_pulse_seen", {63'd0, found}, 64'd1);
        cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_incr = 32'h0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_outclk_en", {61'd0, outclk_en}, 64'd0);
        check("async_rst_locked",    {63'd0, locked},    64'd0);
        check("async_rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        model_reset();
        step();
        cfg_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        wait_locked(0, cyc);
        check("lock_after_async_rst", 64'(cyc), 64'(L));
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        count_pulses(2, 100, cnt);
        check("ch2_init_after_rst", 64'(cnt), 64'd66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
